// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the ID-stage hazard/bypass controller.
// Contents:
//   NREG_DEF/AW_DEF      default register count and address width
//   NBYP_DEF             default number of forwarding stages
//   FLUSH_D_DEF          default bubbles after a flow change
//   MC_LAT_DEF           default multi-cycle issue-to-writeback latency
//   trk_entry_t          in-flight destination tracker entry {v, we, dst, load}
package pipe_ctrl_pkg;

  localparam int unsigned NREG_DEF    = 16;
  localparam int unsigned AW_DEF      = $clog2(NREG_DEF);
  localparam int unsigned NBYP_DEF    = 2;
  localparam int unsigned FLUSH_D_DEF = 2;
  localparam int unsigned MC_LAT_DEF  = 3;

  // Tracker dst is sized for the widest register file we support (256 regs), so the
  // entry type stays fixed while NREG varies; narrower addresses are zero-extended.
  localparam int unsigned TRK_AW = 8;

  typedef struct packed {
    logic              v;
    logic              we;
    logic [TRK_AW-1:0] dst;
    logic              load;
  } trk_entry_t;

endpackage

// File: rtl/dst_track_pipe.sv
// In-flight destination tracker: an NBYP-deep shift pipe of issued instructions.
// Stage k holds the instruction k+1 stages ahead of ID. Shifts every cycle.
// Ports:
//   i_clk, i_rst         clock, async active-high reset
//   i_entry              entry loaded into stage 0 (bubble when v=0)
//   i_re0/i_re1          operand read enables
//   i_p0/i_p1            operand register addresses
//   o_head               stage 0 entry (used for load-use detection)
//   o_match0/o_match1    per-stage forwarding match for operand 0/1
module dst_track_pipe
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned NBYP = 2,
  parameter int unsigned AW   = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  trk_entry_t      i_entry,
  input  logic            i_re0,
  input  logic            i_re1,
  input  logic [AW-1:0]   i_p0,
  input  logic [AW-1:0]   i_p1,
  output trk_entry_t      o_head,
  output logic [NBYP-1:0] o_match0,
  output logic [NBYP-1:0] o_match1
);

  trk_entry_t r_stage [NBYP];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < NBYP; k++) r_stage[k] <= '0;
    end else begin
      r_stage[0] <= i_entry;
      for (int k = 1; k < NBYP; k++) r_stage[k] <= r_stage[k-1];
    end
  end

  assign o_head = r_stage[0];

  logic [TRK_AW-1:0] w_p0;
  logic [TRK_AW-1:0] w_p1;
  logic              w_prod;

  assign w_p0 = TRK_AW'(i_p0);
  assign w_p1 = TRK_AW'(i_p1);

  always_comb begin
    o_match0 = '0;
    o_match1 = '0;
    w_prod   = 1'b0;
    for (int k = 0; k < NBYP; k++) begin
      // Register 0 is hard zero and is never forwarded.
      w_prod      = r_stage[k].v & r_stage[k].we & (r_stage[k].dst != '0);
      o_match0[k] = w_prod & i_re0 & (r_stage[k].dst == w_p0);
      o_match1[k] = w_prod & i_re1 & (r_stage[k].dst == w_p1);
    end
  end

endmodule

// File: rtl/hazard_ctrl_param.sv
// ID-stage hazard/bypass controller. Detects load-use and multi-cycle scoreboard hazards,
// inserts flush bubbles after flow changes, produces registered one-hot bypass selects and
// handles a sticky halt with pipeline drain.
// Ports:
//   i_clk, i_rst                 clock, async active-high reset
//   i_id_valid                   instruction present in IM_ID
//   i_id_re0/1, i_id_p0/1        operand read enables and addresses
//   i_id_we, i_id_dst            register write enable and destination
//   i_id_load, i_id_mc, i_id_hlt load / multi-cycle / halt instruction flags
//   i_flow_change                taken branch/jump resolved in EX
//   o_stall_id                   hold IM_ID and PC
//   o_issue                      ID instruction advances into ID_EX
//   o_kill                       ID_EX loads a bubble
//   o_byp0/o_byp1                one-hot bypass select, bit k = producer k+1 stages ahead
//   o_mc_busy, o_mc_wb, o_mc_wb_dst  multi-cycle occupancy and writeback pulse
//   o_halted, o_drained          sticky halt and drain-complete flags
module hazard_ctrl_param
  import pipe_ctrl_pkg::*;
#(
  parameter  int unsigned NREG    = NREG_DEF,
  parameter  int unsigned NBYP    = NBYP_DEF,
  parameter  int unsigned FLUSH_D = FLUSH_D_DEF,
  parameter  int unsigned MC_LAT  = MC_LAT_DEF,
  localparam int unsigned AW      = $clog2(NREG)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_id_valid,
  input  logic            i_id_re0,
  input  logic            i_id_re1,
  input  logic [AW-1:0]   i_id_p0,
  input  logic [AW-1:0]   i_id_p1,
  input  logic            i_id_we,
  input  logic [AW-1:0]   i_id_dst,
  input  logic            i_id_load,
  input  logic            i_id_mc,
  input  logic            i_id_hlt,
  input  logic            i_flow_change,
  output logic            o_stall_id,
  output logic            o_issue,
  output logic            o_kill,
  output logic [NBYP-1:0] o_byp0,
  output logic [NBYP-1:0] o_byp1,
  output logic            o_mc_busy,
  output logic            o_mc_wb,
  output logic [AW-1:0]   o_mc_wb_dst,
  output logic            o_halted,
  output logic            o_drained
);

  localparam int unsigned FW = $clog2(FLUSH_D) + 1;
  localparam int unsigned CW = $clog2(MC_LAT) + 1;
  localparam int unsigned DW = $clog2(NBYP + 2);
  localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_D - 1);
  localparam logic [CW-1:0] MC_LOAD    = CW'(MC_LAT - 1);
  localparam logic [DW-1:0] DRAIN_N    = DW'(NBYP + 1);

  logic [FW-1:0]   r_flush_cnt;
  logic [CW-1:0]   r_mc_cnt;
  logic [AW-1:0]   r_mc_dst;
  logic [NREG-1:0] r_sb;
  logic            r_halted;
  logic [DW-1:0]   r_drain_cnt;
  logic [NBYP-1:0] r_byp0;
  logic [NBYP-1:0] r_byp1;

  trk_entry_t      w_entry;
  trk_entry_t      w_head;
  logic [NBYP-1:0] w_m0;
  logic [NBYP-1:0] w_m1;
  logic [NBYP-1:0] w_byp0_nxt;
  logic [NBYP-1:0] w_byp1_nxt;
  logic [CW-1:0]   w_mc_cnt_d;
  logic [NREG-1:0] w_sb_d;
  logic            w_luh;
  logic            w_sbh;
  logic            w_hazard;
  logic            w_flushing;
  logic            w_kill;
  logic            w_issue;
  logic            w_mc_busy;
  logic            w_mc_wb;

  always_comb begin
    w_entry      = '0;
    w_entry.v    = w_issue;
    w_entry.we   = i_id_we;
    w_entry.dst  = TRK_AW'(i_id_dst);
    w_entry.load = i_id_load;
  end

  dst_track_pipe #(
    .NBYP (NBYP),
    .AW   (AW)
  ) u_track (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_entry  (w_entry),
    .i_re0    (i_id_re0),
    .i_re1    (i_id_re1),
    .i_p0     (i_id_p0),
    .i_p1     (i_id_p1),
    .o_head   (w_head),
    .o_match0 (w_m0),
    .o_match1 (w_m1)
  );

  // Load result is only available after DM, so a consumer directly behind a load waits a cycle.
  assign w_luh = w_head.v & w_head.load & w_head.we & (w_head.dst != '0) &
                 ((i_id_re0 & (w_head.dst == TRK_AW'(i_id_p0))) |
                  (i_id_re1 & (w_head.dst == TRK_AW'(i_id_p1))));

  assign w_mc_busy = (r_mc_cnt != '0);
  assign w_mc_wb   = (r_mc_cnt == CW'(1));

  // A new multi-cycle op may only start in the writeback cycle of the previous one.
  assign w_sbh = (i_id_re0 & r_sb[i_id_p0]) | (i_id_re1 & r_sb[i_id_p1]) |
                 (i_id_we & r_sb[i_id_dst]) | (i_id_mc & w_mc_busy & (r_mc_cnt > CW'(1)));

  assign w_hazard   = i_id_valid & (w_luh | w_sbh);
  assign w_flushing = i_flow_change | (r_flush_cnt != '0);
  assign w_kill     = w_flushing | w_hazard | r_halted;
  assign w_issue    = i_id_valid & ~w_kill;

  // Flush beats stall: a stalled instruction behind a flow change is discarded, not held.
  assign o_stall_id = (~w_flushing & w_hazard) | r_halted;
  assign o_kill     = w_kill;
  assign o_issue    = w_issue;

  // Lowest stage (youngest producer) wins.
  always_comb begin
    w_byp0_nxt = '0;
    w_byp1_nxt = '0;
    for (int k = NBYP - 1; k >= 0; k--) begin
      if (w_m0[k]) begin
        w_byp0_nxt    = '0;
        w_byp0_nxt[k] = 1'b1;
      end
      if (w_m1[k]) begin
        w_byp1_nxt    = '0;
        w_byp1_nxt[k] = 1'b1;
      end
    end
  end

  always_comb begin
    w_mc_cnt_d = r_mc_cnt;
    if (w_issue & i_id_mc) begin
      w_mc_cnt_d = MC_LOAD;
    end else if (w_mc_busy) begin
      w_mc_cnt_d = r_mc_cnt - CW'(1);
    end
  end

  // Set after clear so a back-to-back op to the same register keeps its bit.
  always_comb begin
    w_sb_d = r_sb;
    if (w_mc_wb) w_sb_d[r_mc_dst] = 1'b0;
    if (w_issue & i_id_mc & (i_id_dst != '0)) w_sb_d[i_id_dst] = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_flush_cnt <= '0;
      r_mc_cnt    <= '0;
      r_mc_dst    <= '0;
      r_sb        <= '0;
      r_halted    <= 1'b0;
      r_drain_cnt <= '0;
      r_byp0      <= '0;
      r_byp1      <= '0;
    end else begin
      if (i_flow_change) begin
        r_flush_cnt <= FLUSH_LOAD;
      end else if (r_flush_cnt != '0) begin
        r_flush_cnt <= r_flush_cnt - FW'(1);
      end
      r_mc_cnt <= w_mc_cnt_d;
      if (w_issue & i_id_mc) r_mc_dst <= i_id_dst;
      r_sb <= w_sb_d;
      if (w_issue & i_id_hlt) r_halted <= 1'b1;
      if (r_halted && (r_drain_cnt != DRAIN_N)) r_drain_cnt <= r_drain_cnt + DW'(1);
      r_byp0 <= w_issue ? w_byp0_nxt : '0;
      r_byp1 <= w_issue ? w_byp1_nxt : '0;
    end
  end

  assign o_byp0      = r_byp0;
  assign o_byp1      = r_byp1;
  assign o_mc_busy   = w_mc_busy;
  assign o_mc_wb     = w_mc_wb;
  assign o_mc_wb_dst = w_mc_wb ? r_mc_dst : '0;
  assign o_halted    = r_halted;
  assign o_drained   = (r_drain_cnt == DRAIN_N);

endmodule

// File: tb/tb_hazard_ctrl_param.sv
module tb_hazard_ctrl_param;

  localparam int NREG    = 16;
  localparam int AW      = 4;
  localparam int NBYP    = 2;
  localparam int FLUSH_D = 2;
  localparam int MC_LAT  = 3;
  localparam int MAXC    = 4000;
  localparam int NRAND   = 2500;

  logic            clk = 1'b0;
  logic            rst;
  logic            id_valid, id_re0, id_re1, id_we, id_load, id_mc, id_hlt, flow_change;
  logic [AW-1:0]   id_p0, id_p1, id_dst;
  logic            stall_id, issue, kill, mc_busy, mc_wb, halted, drained;
  logic [NBYP-1:0] byp0, byp1;
  logic [AW-1:0]   mc_wb_dst;

  always #5 clk = ~clk;

  hazard_ctrl_param #(
    .NREG    (NREG),
    .NBYP    (NBYP),
    .FLUSH_D (FLUSH_D),
    .MC_LAT  (MC_LAT)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_id_valid    (id_valid),
    .i_id_re0      (id_re0),
    .i_id_re1      (id_re1),
    .i_id_p0       (id_p0),
    .i_id_p1       (id_p1),
    .i_id_we       (id_we),
    .i_id_dst      (id_dst),
    .i_id_load     (id_load),
    .i_id_mc       (id_mc),
    .i_id_hlt      (id_hlt),
    .i_flow_change (flow_change),
    .o_stall_id    (stall_id),
    .o_issue       (issue),
    .o_kill        (kill),
    .o_byp0        (byp0),
    .o_byp1        (byp1),
    .o_mc_busy     (mc_busy),
    .o_mc_wb       (mc_wb),
    .o_mc_wb_dst   (mc_wb_dst),
    .o_halted      (halted),
    .o_drained     (drained)
  );

  typedef struct {
    bit stall, iss, kil;
    int b0, b1;
    bit busy, wb;
    int wbdst;
    bit hlt, drn;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   mon_cyc = 0;
  bit   running = 0;

  // Reference model: history of what happened each cycle, queried by age.
  int t  = 0;
  int lr = -1;  // last cycle with reset asserted
  int hc = -1;  // cycle in which HLT issued
  bit a_iss[MAXC], a_we[MAXC], a_ld[MAXC], a_mc[MAXC], a_fc[MAXC];
  int a_dst[MAXC], a_bn0[MAXC], a_bn1[MAXC];

  function automatic bit live(int c);
    return (c >= 0) && (c > lr) && (c < t) && a_iss[c];
  endfunction

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0d want=%0d", nm, mon_cyc, act, exp);
    end
  endtask

  task automatic drv(bit r, bit v, bit re0, bit re1, int p0, int p1, bit we, int dst,
                     bit ld, bit mc, bit hl, bit fc);
    exp_t e;
    bit [NREG-1:0] sb;
    bit luh, sbh, gt1, flushing, hz, found0, found1;
    int b0, b1;
    @(posedge clk);
    #1;
    rst = r; id_valid = v; id_re0 = re0; id_re1 = re1;
    id_p0 = p0[AW-1:0]; id_p1 = p1[AW-1:0]; id_we = we; id_dst = dst[AW-1:0];
    id_load = ld; id_mc = mc; id_hlt = hl; flow_change = fc;
    if (r) begin
      lr = t;
      hc = -1;
    end
    luh = live(t-1) && a_ld[t-1] && a_we[t-1] && a_dst[t-1] != 0 &&
          ((re0 && p0 == a_dst[t-1]) || (re1 && p1 == a_dst[t-1]));
    sb = '0;
    e.busy = 0; e.wb = 0; e.wbdst = 0; gt1 = 0;
    // A multi-cycle op issued at c is busy through c+MC_LAT-1 and writes back then.
    for (int c = t - MC_LAT + 1; c < t; c++) begin
      if (live(c) && a_mc[c]) begin
        if (a_dst[c] != 0) sb[a_dst[c]] = 1'b1;
        e.busy  = 1;
        gt1     = (t < c + MC_LAT - 1);
        e.wb    = (t == c + MC_LAT - 1);
        e.wbdst = a_dst[c];
      end
    end
    sbh = (re0 && sb[p0]) || (re1 && sb[p1]) || (we && sb[dst]) || (mc && e.busy && gt1);
    flushing = fc;
    for (int c = t - FLUSH_D + 1; c < t; c++)
      if (c >= 0 && c > lr && a_fc[c]) flushing = 1;
    e.hlt = (hc >= 0);
    e.drn = e.hlt && (t >= hc + NBYP + 2);
    hz    = v && (luh || sbh);
    e.kil   = flushing || hz || e.hlt;
    e.iss   = v && !e.kil;
    e.stall = (!flushing && hz) || e.hlt;
    e.b0 = live(t-1) ? a_bn0[t-1] : 0;
    e.b1 = live(t-1) ? a_bn1[t-1] : 0;
    b0 = 0; b1 = 0; found0 = 0; found1 = 0;
    for (int k = 0; k < NBYP; k++) begin
      if (live(t-1-k) && a_we[t-1-k] && a_dst[t-1-k] != 0) begin
        if (!found0 && re0 && a_dst[t-1-k] == p0) begin b0 = 1 << k; found0 = 1; end
        if (!found1 && re1 && a_dst[t-1-k] == p1) begin b1 = 1 << k; found1 = 1; end
      end
    end
    a_iss[t] = !r && e.iss; a_we[t] = we; a_ld[t] = ld; a_mc[t] = mc; a_dst[t] = dst;
    a_fc[t] = !r && fc; a_bn0[t] = b0; a_bn1[t] = b1;
    if (!r && e.iss && hl && hc < 0) hc = t;
    q.push_back(e);
    t++;
    running = 1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    if (running) begin
      exp_t e;
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL queue_empty cycle=%0d got=0 want=1", mon_cyc);
      end else begin
        e = q.pop_front();
        chk("stall_id", int'(stall_id), int'(e.stall));
        chk("issue", int'(issue), int'(e.iss));
        chk("kill", int'(kill), int'(e.kil));
        chk("byp0", int'(byp0), e.b0);
        chk("byp1", int'(byp1), e.b1);
        chk("mc_busy", int'(mc_busy), int'(e.busy));
        chk("mc_wb", int'(mc_wb), int'(e.wb));
        if (e.wb) chk("mc_wb_dst", int'(mc_wb_dst), e.wbdst);
        chk("halted", int'(halted), int'(e.hlt));
        chk("drained", int'(drained), int'(e.drn));
      end
      mon_cyc++;
    end
  end

  initial begin
    bit r, v, re0, re1, we, ld, mc, hl, fc;
    int p0, p1, dst;
    rst = 1; id_valid = 0; id_re0 = 0; id_re1 = 0; id_p0 = '0; id_p1 = '0;
    id_we = 0; id_dst = '0; id_load = 0; id_mc = 0; id_hlt = 0; flow_change = 0;
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drv(1, 1, 1, 1, 3, 4, 1, 5, 0, 0, 0, 0);
    idle(1);
    // Load-use: LW R3 then ADD R4,R2,R3 (held while stalled).
    drv(0, 1, 1, 0, 1, 0, 1, 3, 1, 0, 0, 0);
    drv(0, 1, 1, 1, 2, 3, 1, 4, 0, 0, 0, 0);
    drv(0, 1, 1, 1, 2, 3, 1, 4, 0, 0, 0, 0);
    idle(3);
    // Back-to-back ALU forwarding, then the same through R0.
    drv(0, 1, 1, 1, 1, 2, 1, 5, 0, 0, 0, 0);
    drv(0, 1, 1, 1, 5, 5, 1, 6, 0, 0, 0, 0);
    drv(0, 1, 1, 1, 1, 2, 1, 0, 0, 0, 0, 0);
    drv(0, 1, 1, 1, 0, 0, 1, 6, 0, 0, 0, 0);
    idle(3);
    // MUL R7 then ADD R8,R7,R1.
    drv(0, 1, 1, 1, 2, 3, 1, 7, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) drv(0, 1, 1, 1, 7, 1, 1, 8, 0, 0, 0, 0);
    idle(3);
    // Flow change arrives while a load-use stall is pending.
    drv(0, 1, 1, 0, 1, 0, 1, 3, 1, 0, 0, 0);
    drv(0, 1, 1, 1, 3, 2, 1, 4, 0, 0, 0, 1);
    drv(0, 1, 1, 1, 3, 2, 1, 4, 0, 0, 0, 0);
    idle(3);
    // HLT issued, drain, reset; then HLT during a flush has no effect.
    drv(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) drv(0, 1, 1, 0, 1, 0, 1, 2, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drv(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    drv(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(3);
    // Reset mid-MUL in its writeback cycle.
    drv(0, 1, 1, 1, 1, 2, 1, 9, 0, 1, 0, 0);
    idle(1);
    drv(1, 1, 1, 0, 9, 0, 1, 3, 0, 0, 0, 0);
    drv(0, 1, 1, 1, 9, 9, 1, 3, 0, 0, 0, 0);
    idle(3);
    for (int n = 0; n < NRAND; n++) begin
      r   = ($urandom_range(0, 99) < 2) || (hc >= 0 && t - hc > 8);
      v   = $urandom_range(0, 9) < 8;
      re0 = $urandom_range(0, 9) < 6;
      re1 = $urandom_range(0, 9) < 6;
      p0  = $urandom_range(0, 7);
      p1  = $urandom_range(0, 7);
      we  = $urandom_range(0, 9) < 7;
      dst = $urandom_range(0, 7);
      ld  = $urandom_range(0, 9) < 2;
      mc  = $urandom_range(0, 9) < 1;
      hl  = $urandom_range(0, 199) < 1;
      fc  = $urandom_range(0, 99) < 8;
      drv(r, v, re0, re1, p0, p1, we, dst, ld, mc, hl, fc);
    end
    @(negedge clk);
    #1;
    running = 0;
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
